od_io_bank: RTL and testbench

//  N-channel open-drain bidirectional pad controller, one channel per button/pad/LED triple.

---
 rtl/od_io_bank.sv | 211 +++++++++++++++++++++
 tb/tb_od_io_bank.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/od_io_bank.sv
// rtl/od_io_bank.sv - N-channel open-drain pad bank with button debounce, readback and fault flags
//
// Purpose:
//   Each channel debounces a board button and drives its pad low or releases
//   it to an external pull-up (HOLD or TOGGLE behaviour per channel). The pad
//   level is synchronized back and shown on the LED. A sticky per-channel fault
//   flag reports a pad whose level disagrees with the commanded drive for
//   FAULT_CYC consecutive clocks after a SETTLE window following each change.
//
// Ports:
//   clk        in    1     system clock
//   rst        in    1     asynchronous active-low reset
//   btn        in    N_CH  raw buttons, 1 = pressed, asynchronous to clk
//   mode       in    N_CH  0 = HOLD, 1 = TOGGLE, sampled every clock
//   fault_clr  in    N_CH  single-cycle pulse clears fault[i]
//   dio        inout N_CH  pads, 0 while drv_en[i], otherwise Z
//   led        out   N_CH  1 = synchronized pad level is low
//   drv_en     out   N_CH  drive command, 1 = pad pulled low
//   fault      out   N_CH  sticky drive/readback mismatch flag
module od_io_bank #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16,
  parameter int SETTLE      = 4,
  parameter int FAULT_CYC   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  input  logic [N_CH-1:0] mode,
  input  logic [N_CH-1:0] fault_clr,
  inout  wire  [N_CH-1:0] dio,
  output logic [N_CH-1:0] led,
  output logic [N_CH-1:0] drv_en,
  output logic [N_CH-1:0] fault
);

  localparam int DW = $clog2((DEB_CYCLES > 2) ? DEB_CYCLES : 2);
  localparam int FW = $clog2((FAULT_CYC > 2) ? FAULT_CYC : 2);
  // The settle counter is loaded with SETTLE itself, so it needs room for that value.
  localparam int SW = $clog2(((SETTLE + 1) > 2) ? (SETTLE + 1) : 2);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [FW-1:0] FAULT_LAST = FW'(FAULT_CYC - 1);
  localparam logic [SW-1:0] SETTLE_LD  = SW'(SETTLE);

  typedef enum logic {
    ST_REL = 1'b0,
    ST_DRV = 1'b1
  } state_t;

  // Input synchronizers; stage 0 samples the asynchronous source.
  logic [N_CH-1:0] bsync [SYNC_STAGES];
  logic [N_CH-1:0] psync [SYNC_STAGES];
  logic [N_CH-1:0] bs;
  logic [N_CH-1:0] ps;

  // Debounce state.
  logic [DW-1:0]   cnt [N_CH];
  logic [N_CH-1:0] db;
  logic [N_CH-1:0] db_q;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] rel;

  // Drive state machine.
  state_t          state_q [N_CH];
  state_t          state_d [N_CH];
  logic [N_CH-1:0] chg;

  // Fault checker.
  logic [SW-1:0]   st [N_CH];
  logic [FW-1:0]   mc [N_CH];
  logic [N_CH-1:0] mism;
  logic [N_CH-1:0] fault_set;

  assign bs = bsync[SYNC_STAGES-1];
  assign ps = psync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        bsync[s] <= '0;
        psync[s] <= '0;
      end
    end else begin
      bsync[0] <= btn;
      psync[0] <= dio;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        bsync[s] <= bsync[s-1];
        psync[s] <= psync[s-1];
      end
    end
  end

  // A debounced level only follows bs after DEB_CYCLES consecutive disagreeing clocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      db_q <= db;
      for (int i = 0; i < N_CH; i++) begin
        if (bs[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          db[i]  <= bs[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = db & ~db_q;
  assign rel   = ~db & db_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_REL;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // Mode is only consulted when an event arrives, so a mode change never moves the state by itself.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_REL: begin
          if (press[i]) begin
            state_d[i] = ST_DRV;
          end
        end
        ST_DRV: begin
          if (mode[i]) begin
            if (press[i]) begin
              state_d[i] = ST_REL;
            end
          end else if (rel[i]) begin
            state_d[i] = ST_REL;
          end
        end
        default: state_d[i] = ST_REL;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      drv_en[i] = (state_q[i] == ST_DRV);
      chg[i]    = (state_d[i] != state_q[i]);
    end
  end

  // drv_en comes straight from the asynchronously reset state flops, so pads release without a clock.
  for (genvar g = 0; g < N_CH; g++) begin : g_pad
    assign dio[g] = drv_en[g] ? 1'b0 : 1'bz;
  end

  // Driving expects the pad low, releasing expects it high: equality means disagreement.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      mism[i]      = (ps[i] == drv_en[i]);
      fault_set[i] = !chg[i] && (st[i] == '0) && mism[i] && (mc[i] == FAULT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led   <= '0;
      fault <= '0;
      for (int i = 0; i < N_CH; i++) begin
        st[i] <= '0;
        mc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        led[i] <= ~ps[i];

        if (chg[i]) begin
          st[i] <= SETTLE_LD;
          mc[i] <= '0;
        end else if (st[i] != '0) begin
          st[i] <= st[i] - 1'b1;
          mc[i] <= '0;
        end else if (fault_clr[i] || !mism[i]) begin
          mc[i] <= '0;
        end else if (mc[i] != FAULT_LAST) begin
          mc[i] <= mc[i] + 1'b1;
        end

        // Clear has priority over a coincident set.
        if (fault_clr[i]) begin
          fault[i] <= 1'b0;
        end else if (fault_set[i]) begin
          fault[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_od_io_bank.sv
// tb/tb_od_io_bank.sv - testbench for od_io_bank
module tb_od_io_bank;

  localparam int N   = 4;
  localparam int SS  = 2;
  localparam int DEB = 16;
  localparam int SET = 4;
  localparam int FC  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] mode;
  logic [3:0] fault_clr;
  logic [3:0] ovr_en;
  logic [3:0] ovr_val;
  wire  [3:0] dio;
  logic [3:0] led;
  logic [3:0] drv_en;
  logic [3:0] fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  od_io_bank #(
    .N_CH(N), .SYNC_STAGES(SS), .DEB_CYCLES(DEB), .SETTLE(SET), .FAULT_CYC(FC)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .mode(mode), .fault_clr(fault_clr),
    .dio(dio), .led(led), .drv_en(drv_en), .fault(fault)
  );

  // Board side: pull-up on every pad plus an optional external driver per pad.
  for (genvar g = 0; g < N; g++) begin : g_board
    pullup pu (dio[g]);
    assign dio[g] = ovr_en[g] ? ovr_val[g] : 1'bz;
  end

  // Reference model: delay lines for the synchronizers, run lengths for debounce and mismatch.
  logic [3:0] m_drv, m_led, m_fault, m_db, m_press, m_rel;
  int         m_run [N];
  int         m_st  [N];
  int         m_mis [N];
  logic [3:0] bq [$];
  logic [3:0] pq [$];

  function automatic logic [3:0] pad_model();
    logic [3:0] p;
    for (int i = 0; i < N; i++) p[i] = ovr_en[i] ? ovr_val[i] : ~m_drv[i];
    return p;
  endfunction

  task automatic model_reset();
    m_drv = '0; m_led = '0; m_fault = '0; m_db = '0; m_press = '0; m_rel = '0;
    for (int i = 0; i < N; i++) begin m_run[i] = 0; m_st[i] = 0; m_mis[i] = 0; end
    bq.delete(); pq.delete();
    repeat (SS) begin bq.push_back(4'h0); pq.push_back(4'h0); end
  endtask

  task automatic model_step();
    logic [3:0] bsv, psv, pad, nd;
    logic       set_f;
    bsv = bq[SS-1];
    psv = pq[SS-1];
    pad = pad_model();
    bq.push_front(btn); void'(bq.pop_back());
    pq.push_front(pad); void'(pq.pop_back());
    nd = m_drv;
    for (int i = 0; i < N; i++) begin
      if (m_press[i]) nd[i] = mode[i] ? ~m_drv[i] : 1'b1;
      else if (m_rel[i] && !mode[i]) nd[i] = 1'b0;
      set_f = 1'b0;
      if (nd[i] != m_drv[i]) begin m_st[i] = SET; m_mis[i] = 0; end
      else if (m_st[i] > 0) begin m_st[i] = m_st[i] - 1; m_mis[i] = 0; end
      else if (fault_clr[i] || (psv[i] != m_drv[i])) m_mis[i] = 0;
      else if (m_mis[i] >= FC - 1) set_f = 1'b1;
      else m_mis[i] = m_mis[i] + 1;
      if (fault_clr[i]) m_fault[i] = 1'b0;
      else if (set_f) m_fault[i] = 1'b1;
      m_led[i]   = ~psv[i];
      m_press[i] = 1'b0;
      m_rel[i]   = 1'b0;
      if (bsv[i] != m_db[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DEB) begin
          m_db[i] = bsv[i]; m_run[i] = 0; m_press[i] = bsv[i]; m_rel[i] = ~bsv[i];
        end
      end else m_run[i] = 0;
    end
    m_drv = nd;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; btn = '0; mode = '0; fault_clr = '0; ovr_en = '0; ovr_val = '0;
    model_reset();
    repeat (3) cyc();
    n_cmp++;
    if ({led, drv_en, fault} !== 12'h000) begin
      n_err++; $display("FAIL reset_outputs: got %h required 000", {led, drv_en, fault});
    end
    n_cmp++;
    if (dio !== 4'hf) begin n_err++; $display("FAIL reset_pads: got %b required 1111", dio); end
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      n_cmp++;
      if ({drv_en, led, fault, dio} !== {m_drv, m_led, m_fault, pad_model()}) begin
        n_err++; $display("FAIL reset_release_model c%0d: got %h required %h", c, {drv_en, led, fault, dio}, {m_drv, m_led, m_fault, pad_model()});
      end
    end
  endtask

  task automatic test_hold();
    int t_drv, t_led, t_rel;
    t_drv = -1; t_led = -1; t_rel = -1;
    mode[0] = 1'b0; btn[0] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      n_cmp++;
      if ({drv_en, led, fault, dio} !== {m_drv, m_led, m_fault, pad_model()}) begin
        n_err++; $display("FAIL hold_model c%0d: got %h required %h", c, {drv_en, led, fault, dio}, {m_drv, m_led, m_fault, pad_model()});
      end
      if (t_drv < 0 && drv_en[0]) t_drv = c;
      if (t_led < 0 && led[0]) t_led = c;
    end
    n_cmp++;
    if (t_drv < 18 || t_drv > 20) begin n_err++; $display("FAIL hold_press_latency: got %0d required 18..20", t_drv); end
    n_cmp++;
    if (t_led != t_drv + SS + 1) begin n_err++; $display("FAIL hold_led_latency: got %0d required %0d", t_led, t_drv + SS + 1); end
    n_cmp++;
    if (dio[0] !== 1'b0 || led[0] !== 1'b1) begin n_err++; $display("FAIL hold_driven: got dio=%b led=%b required 0 1", dio[0], led[0]); end
    btn[0] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      n_cmp++;
      if ({drv_en, led, fault, dio} !== {m_drv, m_led, m_fault, pad_model()}) begin
        n_err++; $display("FAIL hold_rel_model c%0d: got %h required %h", c, {drv_en, led, fault, dio}, {m_drv, m_led, m_fault, pad_model()});
      end
      if (t_rel < 0 && !drv_en[0]) t_rel = c;
    end
    n_cmp++;
    if (t_rel < 18 || t_rel > 20) begin n_err++; $display("FAIL hold_release_latency: got %0d required 18..20", t_rel); end
    n_cmp++;
    if (dio[0] !== 1'b1 || led[0] !== 1'b0) begin n_err++; $display("FAIL hold_released: got dio=%b led=%b required 1 0", dio[0], led[0]); end
  endtask

  task automatic test_debounce();
    logic seen, prev;
    int   rises;
    seen = 1'b0; mode[1] = 1'b0;
    repeat (4) begin
      btn[1] = 1'b1;
      repeat (10) begin cyc(); seen |= drv_en[1]; end
      btn[1] = 1'b0;
      repeat (10) begin cyc(); seen |= drv_en[1]; end
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL debounce_glitch: got drive %b required 0", seen); end
    mode[1] = 1'b1; rises = 0; prev = drv_en[1];
    btn[1] = 1'b1;
    for (int c = 0; c < 57; c++) begin
      if (c == 17) btn[1] = 1'b0;
      cyc();
      if (drv_en[1] && !prev) rises++;
      prev = drv_en[1];
      n_cmp++;
      if ({drv_en, led, fault} !== {m_drv, m_led, m_fault}) begin
        n_err++; $display("FAIL debounce_model c%0d: got %h required %h", c, {drv_en, led, fault}, {m_drv, m_led, m_fault});
      end
    end
    n_cmp++;
    if (rises != 1 || drv_en[1] !== 1'b1) begin n_err++; $display("FAIL debounce_toggle_once: got rises=%0d drv=%b required 1 1", rises, drv_en[1]); end
  endtask

  task automatic test_toggle();
    logic exp_d;
    exp_d = 1'b0; mode[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      btn[2] = 1'b1;
      repeat (30) cyc();
      exp_d = ~exp_d;
      n_cmp++;
      if (drv_en[2] !== exp_d) begin n_err++; $display("FAIL toggle_press%0d: got %b required %b", k, drv_en[2], exp_d); end
      btn[2] = 1'b0;
      repeat (30) cyc();
      n_cmp++;
      if (drv_en[2] !== exp_d) begin n_err++; $display("FAIL toggle_release%0d: got %b required %b", k, drv_en[2], exp_d); end
    end
  endtask

  task automatic test_ext_low();
    int t_led, t_flt, t_re;
    t_led = -1; t_flt = -1; t_re = -1;
    ovr_en[3] = 1'b1; ovr_val[3] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (t_led < 0 && led[3]) t_led = c;
      if (t_flt < 0 && fault[3]) t_flt = c;
    end
    n_cmp++;
    if (t_led != SS + 1) begin n_err++; $display("FAIL extlow_led: got %0d required %0d", t_led, SS + 1); end
    n_cmp++;
    if (t_flt != FC + SS) begin n_err++; $display("FAIL extlow_fault: got %0d required %0d", t_flt, FC + SS); end
    n_cmp++;
    if (drv_en[3] !== 1'b0) begin n_err++; $display("FAIL extlow_drive: got %b required 0", drv_en[3]); end
    fault_clr[3] = 1'b1; cyc(); fault_clr[3] = 1'b0;
    n_cmp++;
    if (fault[3] !== 1'b0) begin n_err++; $display("FAIL extlow_clear: got %b required 0", fault[3]); end
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (t_re < 0 && fault[3]) t_re = c;
    end
    n_cmp++;
    if (t_re != FC) begin n_err++; $display("FAIL extlow_reset_fault: got %0d required %0d", t_re, FC); end
    ovr_en[3] = 1'b0;
    repeat (5) cyc();
    fault_clr[3] = 1'b1; cyc(); fault_clr[3] = 1'b0;
    repeat (5) cyc();
    n_cmp++;
    if (fault[3] !== 1'b0 || led[3] !== 1'b0) begin n_err++; $display("FAIL extlow_recover: got fault=%b led=%b required 0 0", fault[3], led[3]); end
  endtask

  task automatic test_stuck_high();
    int t_flt, waited;
    t_flt = -1; waited = 0;
    mode[0] = 1'b0; btn[0] = 1'b1;
    while (!drv_en[0] && waited < 30) begin cyc(); waited++; end
    n_cmp++;
    if (drv_en[0] !== 1'b1) begin n_err++; $display("FAIL stuck_wait_drive: got %b required 1 within 30 clk", drv_en[0]); end
    ovr_en[0] = 1'b1; ovr_val[0] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (t_flt < 0 && fault[0]) t_flt = c;
      n_cmp++;
      if ({drv_en, led, fault} !== {m_drv, m_led, m_fault}) begin
        n_err++; $display("FAIL stuck_model c%0d: got %h required %h", c, {drv_en, led, fault}, {m_drv, m_led, m_fault});
      end
    end
    n_cmp++;
    if (t_flt != SET + FC) begin n_err++; $display("FAIL stuck_fault: got %0d required %0d", t_flt, SET + FC); end
    n_cmp++;
    if (drv_en[0] !== 1'b1) begin n_err++; $display("FAIL stuck_drive_kept: got %b required 1", drv_en[0]); end
    ovr_en[0] = 1'b0; btn[0] = 1'b0;
    repeat (30) cyc();
    fault_clr[0] = 1'b1; cyc(); fault_clr[0] = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_random();
    for (int c = 0; c < 900; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0) btn[i] = ~btn[i];
        if ($urandom_range(0, 99) == 0) mode[i] = ~mode[i];
        fault_clr[i] = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 79) == 0) begin ovr_en[i] = ~ovr_en[i]; ovr_val[i] = 1'($urandom_range(0, 1)); end
      end
      cyc();
      n_cmp++;
      if ({drv_en, led, fault, dio} !== {m_drv, m_led, m_fault, pad_model()}) begin
        n_err++; $display("FAIL random_model c%0d: got %h required %h", c, {drv_en, led, fault, dio}, {m_drv, m_led, m_fault, pad_model()});
      end
    end
    fault_clr = '0; ovr_en = '0;
  endtask

  task automatic test_reset_mid_drive();
    int waited, t_drv;
    logic early;
    waited = 0; t_drv = -1; early = 1'b0;
    mode = '0; btn = '0;
    repeat (40) cyc();
    btn = 4'hf;
    while (drv_en !== 4'hf && waited < 60) begin cyc(); waited++; end
    n_cmp++;
    if (drv_en !== 4'hf) begin n_err++; $display("FAIL midrst_wait_drive: got %b required 1111", drv_en); end
    @(posedge clk); #2; rst = 1'b0; #1;
    n_cmp++;
    if (dio !== 4'hf || drv_en !== 4'h0) begin n_err++; $display("FAIL midrst_async_release: got dio=%b drv=%b required 1111 0000", dio, drv_en); end
    model_reset();
    @(negedge clk);
    repeat (2) cyc();
    n_cmp++;
    if ({led, drv_en, fault} !== 12'h000) begin n_err++; $display("FAIL midrst_outputs: got %h required 000", {led, drv_en, fault}); end
    rst = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      cyc();
      if (c <= 17 && drv_en !== 4'h0) early = 1'b1;
      if (t_drv < 0 && drv_en == 4'hf) t_drv = c;
      n_cmp++;
      if ({drv_en, led, fault, dio} !== {m_drv, m_led, m_fault, pad_model()}) begin
        n_err++; $display("FAIL midrst_model c%0d: got %h required %h", c, {drv_en, led, fault, dio}, {m_drv, m_led, m_fault, pad_model()});
      end
    end
    n_cmp++;
    if (early) begin n_err++; $display("FAIL midrst_early_drive: got drive within 17 clk required none"); end
    n_cmp++;
    if (t_drv < 18 || t_drv > 20) begin n_err++; $display("FAIL midrst_redrive: got %0d required 18..20", t_drv); end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_debounce();
    test_toggle();
    test_ext_low();
    test_stuck_high();
    test_random();
    test_reset_mid_drive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
